drp_reconf_master: RTL

Initiator for the PLL dynamic reconfiguration port; drives DADDR/DEN/DWE/DI and consumes DO/DRDY from the PLL's reconfiguration responder. On a START pulse it holds the PLL in reset, then performs a masked read-modify-write for each entry of an external register table. It then releases reset and waits for LOCKED. It sits next to the PLL model in benches and wrappers, clocked by the same DCLK that feeds the PLL's DRP.

---
 rtl/drp_reconf_master_pkg.sv | 54 +++++
 rtl/drp_reconf_master_timer.sv | 41 ++++
 rtl/drp_reconf_master.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/drp_reconf_master_pkg.sv
// Shared definitions for the DRP reconfiguration master: FSM state
// encodings, DRP bus widths, PLL register map and the read-modify-write
// merge used when building a write word.
package drp_reconf_master_pkg;

   // DRP bus geometry
   localparam int DRP_ADDR_W = 7;
   localparam int DRP_DATA_W = 16;

   // Width of the shared cycle timer
   localparam int TIMER_W = 32;

   // FSM state encodings
   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
   localparam logic [STATE_W-1:0] ST_ASSERT_RST = 3'd1;
   localparam logic [STATE_W-1:0] ST_READ       = 3'd2;
   localparam logic [STATE_W-1:0] ST_WAIT_RD    = 3'd3;
   localparam logic [STATE_W-1:0] ST_WRITE      = 3'd4;
   localparam logic [STATE_W-1:0] ST_WAIT_WR    = 3'd5;
   localparam logic [STATE_W-1:0] ST_RELEASE    = 3'd6;
   localparam logic [STATE_W-1:0] ST_WAIT_LOCK  = 3'd7;

   // PLL register addresses shared with the reconfiguration responder.
   // Each output divider owns two registers (REG1: high/low time,
   // REG2: phase/edge/no-count).
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT5_REG1  = 7'h06;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT5_REG2  = 7'h07;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT0_REG1  = 7'h08;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT0_REG2  = 7'h09;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT1_REG1  = 7'h0A;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT1_REG2  = 7'h0B;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT2_REG1  = 7'h0C;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT2_REG2  = 7'h0D;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT3_REG1  = 7'h0E;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT3_REG2  = 7'h0F;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT4_REG1  = 7'h10;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT4_REG2  = 7'h11;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT6_REG1  = 7'h12;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT6_REG2  = 7'h13;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKFBOUT_REG1 = 7'h14;
   localparam logic [DRP_ADDR_W-1:0] ADDR_CLKFBOUT_REG2 = 7'h15;
   localparam logic [DRP_ADDR_W-1:0] ADDR_DIVCLK        = 7'h16;

   // Masked merge: mask bit 1 keeps the value read back, 0 takes new data.
   function automatic logic [DRP_DATA_W-1:0] rmw_merge(
      input logic [DRP_DATA_W-1:0] rd_val,
      input logic [DRP_DATA_W-1:0] new_val,
      input logic [DRP_DATA_W-1:0] keep_mask
   );
      return (rd_val & keep_mask) | (new_val & ~keep_mask);
   endfunction

endpackage

// File: rtl/drp_reconf_master_timer.sv
// drp_timer: saturating up-counter with synchronous clear and enable.
// expired_o compares the current count against a caller-supplied limit so
// one instance can time the reset hold, DRDY waits and the lock wait.
module drp_timer
   import drp_reconf_master_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [TIMER_W-1:0] limit_i,
   output logic [TIMER_W-1:0] count_o,
   output logic               expired_o
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   // Next count: clear wins, otherwise count up and stick at all-ones
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != {TIMER_W{1'b1}})) begin
         count_d = count_q + TIMER_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign expired_o = (count_q >= limit_i);

endmodule

// File: rtl/drp_reconf_master.sv
// drp_reconf_master: holds the PLL in reset, walks an external register
// table doing a masked read-modify-write per entry over DRP, releases the
// reset and waits for LOCKED. One shared timer covers every wait.
//
// DRP handshake: a request is a single-cycle DEN with DADDR (and DWE/DI for
// writes) valid in that cycle; the responder answers with one single-cycle
// DRDY, DO valid with it on reads. DADDR/DI stay put until that DRDY and no
// new DEN is issued while a request is outstanding.
module drp_reconf_master
   import drp_reconf_master_pkg::*;
#(
   parameter int MAX_ENTRIES  = 16,
   parameter int RST_HOLD     = 4,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 100000,
   localparam int IDX_W       = $clog2(MAX_ENTRIES),
   localparam int NUM_W       = IDX_W + 1
) (
   input  logic                  DCLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [NUM_W-1:0]      TBL_NUM,
   output logic [IDX_W-1:0]      TBL_IDX,
   input  logic [DRP_ADDR_W-1:0] TBL_ADDR,
   input  logic [DRP_DATA_W-1:0] TBL_DATA,
   input  logic [DRP_DATA_W-1:0] TBL_MASK,
   output logic [DRP_ADDR_W-1:0] DADDR,
   output logic                  DEN,
   output logic                  DWE,
   output logic [DRP_DATA_W-1:0] DI,
   input  logic [DRP_DATA_W-1:0] DO,
   input  logic                  DRDY,
   output logic                  PLL_RST,
   input  logic                  LOCKED,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERROR,
   output logic [STATE_W-1:0]    DBG_STATE
);

   // Timer limits: the timer reads 0 in the first cycle of each timed
   // phase, so a limit of N-1 ends the phase after exactly N cycles.
   localparam logic [TIMER_W-1:0] HOLD_LIM = TIMER_W'(RST_HOLD - 1);
   localparam logic [TIMER_W-1:0] DRDY_LIM = TIMER_W'(DRDY_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] LOCK_LIM = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [NUM_W-1:0]   NUM_MAX  = NUM_W'(MAX_ENTRIES);

   logic [STATE_W-1:0]    state_q,   state_d;
   logic [NUM_W-1:0]      num_q,     num_d;
   logic [IDX_W-1:0]      idx_q,     idx_d;
   logic [DRP_DATA_W-1:0] rd_q,      rd_d;
   logic [DRP_ADDR_W-1:0] daddr_q,   daddr_d;
   logic [DRP_DATA_W-1:0] di_q,      di_d;
   logic                  pll_rst_q, pll_rst_d;
   logic                  done_q,    done_d;
   logic                  error_q,   error_d;

   logic                  tmr_clr;
   logic                  tmr_en;
   logic [TIMER_W-1:0]    tmr_limit;
   logic [TIMER_W-1:0]    tmr_count;
   logic                  tmr_expired;

   logic [NUM_W-1:0]      num_clamped;
   logic                  last_entry;
   logic [DRP_DATA_W-1:0] wr_word;

   assign num_clamped = (TBL_NUM > NUM_MAX) ? NUM_MAX : TBL_NUM;
   assign last_entry  = ({1'b0, idx_q} == (num_q - NUM_W'(1)));
   assign wr_word     = rmw_merge(rd_q, TBL_DATA, TBL_MASK);

   // Pick the timer limit for the phase the FSM is in
   always_comb begin
      tmr_limit = '0;
      case (state_q)
         ST_ASSERT_RST:                             tmr_limit = HOLD_LIM;
         ST_READ, ST_WAIT_RD, ST_WRITE, ST_WAIT_WR: tmr_limit = DRDY_LIM;
         ST_RELEASE, ST_WAIT_LOCK:                  tmr_limit = LOCK_LIM;
         default:                                   tmr_limit = '0;
      endcase
   end

   assign tmr_en = (state_q != ST_IDLE);

   drp_timer u_timer (
      .clk_i     (DCLK),
      .rst_i     (RST),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .limit_i   (tmr_limit),
      .count_o   (tmr_count),
      .expired_o (tmr_expired)
   );

   // FSM next-state and datapath updates; the timer is cleared on every
   // entry into a timed phase so DRP waits count from the DEN cycle.
   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      idx_d     = idx_q;
      rd_d      = rd_q;
      daddr_d   = daddr_q;
      di_d      = di_q;
      pll_rst_d = pll_rst_q;
      error_d   = error_q;
      done_d    = 1'b0;
      tmr_clr   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d   = ST_ASSERT_RST;
               num_d     = num_clamped;
               idx_d     = '0;
               error_d   = 1'b0;
               pll_rst_d = 1'b1;
               tmr_clr   = 1'b1;
            end
         end
         ST_ASSERT_RST: begin
            if (tmr_expired) begin
               tmr_clr = 1'b1;
               if (num_q != '0) begin
                  state_d = ST_READ;
               end else begin
                  state_d   = ST_RELEASE;
                  pll_rst_d = 1'b0;
               end
            end
         end
         ST_READ: begin
            daddr_d = TBL_ADDR;
            state_d = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            // DRDY on the expiry cycle still counts as a completed read
            if (DRDY) begin
               rd_d    = DO;
               state_d = ST_WRITE;
               tmr_clr = 1'b1;
            end else if (tmr_expired) begin
               error_d   = 1'b1;
               pll_rst_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_WRITE: begin
            di_d    = wr_word;
            state_d = ST_WAIT_WR;
         end
         ST_WAIT_WR: begin
            if (DRDY) begin
               tmr_clr = 1'b1;
               if (last_entry) begin
                  state_d   = ST_RELEASE;
                  pll_rst_d = 1'b0;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_READ;
               end
            end else if (tmr_expired) begin
               error_d   = 1'b1;
               pll_rst_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_RELEASE: begin
            state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // Timer is 1 in the first WAIT_LOCK cycle; LOCKED is ignored there
            if (LOCKED && (tmr_count >= TIMER_W'(2))) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (tmr_expired) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge DCLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         num_q     <= '0;
         idx_q     <= '0;
         rd_q      <= '0;
         daddr_q   <= '0;
         di_q      <= '0;
         pll_rst_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         idx_q     <= idx_d;
         rd_q      <= rd_d;
         daddr_q   <= daddr_d;
         di_q      <= di_d;
         pll_rst_q <= pll_rst_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   // In the DEN cycle address/data come straight from the table; the
   // registered copies then hold them until the matching DRDY.
   assign DADDR     = (state_q == ST_READ)  ? TBL_ADDR : daddr_q;
   assign DI        = (state_q == ST_WRITE) ? wr_word  : di_q;
   assign DEN       = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign DWE       = (state_q == ST_WRITE);
   assign TBL_IDX   = idx_q;
   assign PLL_RST   = pll_rst_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign DONE      = done_q;
   assign ERROR     = error_q;
   assign DBG_STATE = state_q;

endmodule
